jk_bank_arbiter: RTL and testbench

//  Shares a bank of NBITS JK flip-flops between NREQ requesters.

---
 rtl/jk_pkg.sv | 15 +
 rtl/jk_cell.sv | 15 +
 rtl/jk_bank_arbiter.sv | 120 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank arbiter: command codes and FSM states.
package jk_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with asynchronous active-low clear.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= (J & ~q) | (~K & q);
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters issue one-cycle J/K commands
// into a shared bank of NBITS JK cells, one command every three cycles.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [2*NREQ-1:0]                req_cmd,
  input  logic [$clog2(NBITS)*NREQ-1:0]    req_idx,
  output logic [NREQ-1:0]                  req_ready,
  output logic [NBITS-1:0]                 q,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(NREQ)-1:0]          done_id,
  output logic                             err
);

  localparam int unsigned IDXW = $clog2(NBITS);
  localparam int unsigned IDW  = $clog2(NREQ);

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr, win_q, win_c, rr_next;
  logic [IDW-1:0]     cand [NREQ];
  logic               found_c, accept_c;
  logic [1:0]         cmd_q;
  logic [IDXW-1:0]    idx_q;
  logic [NBITS-1:0]   j_c, k_c;

  // Candidate requester order, starting at rr_ptr and wrapping
  for (genvar g = 0; g < NREQ; g++) begin : g_cand
    assign cand[g] = IDW'((32'(rr_ptr) + 32'(g)) % 32'(NREQ));
  end

  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_c && req_valid[cand[i]]) begin
        found_c = 1'b1;
        win_c   = cand[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Ready is gated by rst so no grant is advertised while reset is held
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_c && rst) begin
          req_ready[win_c] = 1'b1;
          accept_c         = 1'b1;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign rr_next = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q  <= CMD_HOLD;
      idx_q  <= '0;
      win_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept_c) begin
        cmd_q <= req_cmd[2*win_c +: 2];
        idx_q <= req_idx[IDXW*win_c +: IDXW];
        win_q <= win_c;
      end
      if (state_q == S_SETTLE) rr_ptr <= rr_next;
    end
  end

  // Out-of-range indices match no cell, so the bank sees J=K=0 everywhere
  always_comb begin
    j_c = '0;
    k_c = '0;
    if (state_q == S_ISSUE) begin
      for (int unsigned b = 0; b < NBITS; b++) begin
        if (32'(idx_q) == b) begin
          j_c[b] = cmd_q[1];
          k_c[b] = cmd_q[0];
        end
      end
    end
  end

  for (genvar b = 0; b < NBITS; b++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .J   (j_c[b]),
      .K   (k_c[b]),
      .q   (q[b])
    );
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_SETTLE);
  assign done_id = done ? win_q : '0;
  assign err     = done && (32'(idx_q) >= NBITS);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: scoreboard of expected completions,
// an 8-bit bank instance and a 6-bit instance for out-of-range indices.
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  typedef struct {
    int unsigned id;
    logic [7:0]  q;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid, valid6;
  logic [7:0]  cmd, cmd6;
  logic [11:0] idx, idx6;
  logic [3:0]  ready, ready6;
  logic [7:0]  q;
  logic [5:0]  q6;
  logic        busy, busy6, done, done6, err, err6;
  logic [1:0]  done_id, done_id6;

  int          n_err = 0;
  int          n_checks = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  logic [7:0]  mq = '0;
  logic [7:0]  mq6 = '0;
  exp_t        sb[$];

  jk_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_cmd(cmd), .req_idx(idx),
    .req_ready(ready), .q(q), .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  jk_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
    .clk(clk), .rst(rst), .req_valid(valid6), .req_cmd(cmd6), .req_idx(idx6),
    .req_ready(ready6), .q(q6), .busy(busy6), .done(done6), .done_id(done_id6), .err(err6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] apply(input logic [7:0] v, input logic [1:0] c, input int unsigned ix);
    logic [7:0] r;
    r = v;
    case (c)
      CMD_RST: r[ix] = 1'b0;
      CMD_SET: r[ix] = 1'b1;
      CMD_TGL: r[ix] = ~v[ix];
      default: r = v;
    endcase
    return r;
  endfunction

  // Drive one command at a negedge, check the grant, push the expectation
  task automatic issue(input bit six, input int r, input logic [1:0] c, input int unsigned ix);
    exp_t        e;
    logic [7:0]  prev;
    logic [3:0]  one;
    int unsigned nb;
    nb   = six ? 6 : 8;
    prev = six ? mq6 : mq;
    one  = 4'(1 << r);
    if (six) begin
      valid6[r] = 1'b1; cmd6[2*r +: 2] = c; idx6[3*r +: 3] = 3'(ix);
    end else begin
      valid[r] = 1'b1; cmd[2*r +: 2] = c; idx[3*r +: 3] = 3'(ix);
    end
    #1;
    chk($sformatf("ready_r%0d", r), six ? 32'(ready6) : 32'(ready), 32'(one));
    e.id  = r;
    e.err = (ix >= nb);
    e.q   = e.err ? prev : apply(prev, c, ix);
    if (six) mq6 = e.q; else mq = e.q;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (six) valid6[r] = 1'b0; else valid[r] = 1'b0;
    chk("busy_issue", six ? 32'(busy6) : 32'(busy), 32'd1);
    chk("q_before_e1", six ? 32'(q6) : 32'(q), 32'(prev));
  endtask

  // Wait (bounded) for done, pop the scoreboard and compare
  task automatic wait_done(input bit six);
    exp_t e;
    int   n = 0;
    while (!(six ? done6 : done) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!(six ? done6 : done)) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    done_cyc = cyc;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("done_id", six ? 32'(done_id6) : 32'(done_id), 32'(e.id));
    chk("err", six ? 32'(err6) : 32'(err), 32'(e.err));
    chk("q_after", six ? 32'(q6) : 32'(q), 32'(e.q));
    @(negedge clk);
    chk("done_pulse_end", six ? 32'(done6) : 32'(done), 32'd0);
    chk("busy_idle", six ? 32'(busy6) : 32'(busy), 32'd0);
  endtask

  task automatic clear_inputs();
    valid = '0; cmd = '0; idx = '0;
    valid6 = '0; cmd6 = '0; idx6 = '0;
  endtask

  initial begin
    int c0, c1, c2;
    // 1. reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 4'($urandom); cmd = 8'($urandom); idx = 12'($urandom);
      valid6 = 4'($urandom); cmd6 = 8'($urandom); idx6 = 12'($urandom);
      @(negedge clk);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_ctl", {28'd0, busy, done, err, |ready}, 32'd0);
      chk("rst_q6", 32'(q6), 32'h00);
    end
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);

    // 2. single set
    issue(0, 1, CMD_SET, 3);
    wait_done(0);
    chk("single_q", 32'(q), 32'h08);

    // 3. toggle, toggle, reset on bit 5 back to back
    issue(0, 0, CMD_TGL, 5);
    wait_done(0);
    c0 = done_cyc;
    chk("tgl1_q5", 32'(q[5]), 32'd1);
    issue(0, 0, CMD_TGL, 5);
    wait_done(0);
    c1 = done_cyc;
    chk("tgl2_q5", 32'(q[5]), 32'd0);
    issue(0, 0, CMD_RST, 5);
    wait_done(0);
    c2 = done_cyc;
    chk("rst_q5", 32'(q[5]), 32'd0);
    chk("done_gap1", 32'(c1 - c0), 32'd3);
    chk("done_gap2", 32'(c2 - c1), 32'd3);

    // 5. out-of-range on the 6-bit bank
    issue(1, 2, CMD_SET, 2);
    wait_done(1);
    issue(1, 2, CMD_SET, 7);
    wait_done(1);
    chk("oor_q6", 32'(q6), 32'h04);

    // 4. fairness from a fresh reset
    rst = 1'b0;
    mq = '0; mq6 = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      valid[r] = 1'b1; cmd[2*r +: 2] = CMD_SET; idx[3*r +: 3] = 3'(r);
    end
    for (int g = 0; g < 4; g++) begin
      issue(0, g, CMD_SET, g);
      wait_done(0);
    end
    chk("fair_q", 32'(q), 32'h0F);

    // rr_ptr wrapped to 0: requester 0 beats 1; hold leaves q alone
    valid[1] = 1'b1; cmd[3:2] = CMD_HOLD; idx[5:3] = 3'd6;
    issue(0, 0, CMD_HOLD, 6);
    wait_done(0);
    issue(0, 1, CMD_HOLD, 6);
    wait_done(0);
    chk("hold_q", 32'(q), 32'h0F);

    // 6. reset in the middle of ISSUE
    valid[2] = 1'b1; cmd[5:4] = CMD_SET; idx[8:6] = 3'd4;
    #1;
    chk("mid_ready", 32'(ready), 32'h4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    valid[2] = 1'b0;
    #1;
    chk("mid_async", {23'd0, q, busy}, 32'd0);
    mq = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_done", {30'd0, done, busy}, 32'd0);
    end
    valid[3] = 1'b1; cmd[7:6] = CMD_TGL; idx[11:9] = 3'd7;
    issue(0, 0, CMD_SET, 1);
    wait_done(0);
    issue(0, 3, CMD_TGL, 7);
    wait_done(0);
    chk("post_rst_q", 32'(q), 32'h82);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
